// File: rtl/turbo_punc_mux.sv
// Turbo encoder output stage: collects systematic, parity-1 and parity-2 nibbles,
// optionally punctures them to rate 1/2 and emits one framed serial bitstream.
module turbo_punc_mux #(
    parameter bit RATE_HALF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] msg,
    input  logic       msg_vld,
    input  logic [3:0] c_1,
    input  logic       c1_over,
    input  logic [3:0] c_2,
    input  logic       c2_over,
    output logic       dout,
    output logic       dout_vld,
    output logic       sof,
    output logic       eof,
    output logic       busy,
    output logic       ovr_err
);

    localparam int         N_BITS   = RATE_HALF ? 8 : 12;
    localparam logic [3:0] CNT_LAST = 4'(N_BITS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] sr_q, sr_d;
    logic [3:0]  msg_q, msg_d;
    logic [3:0]  p1_q, p1_d;
    logic [3:0]  p2_q, p2_d;
    logic        f_msg_q, f_msg_d;
    logic        f_p1_q, f_p1_d;
    logic        f_p2_q, f_p2_d;
    logic        ovr_q, ovr_d;

    logic        all_set;
    logic        last_bit;
    logic        load;

    // Bit i of the returned word is the i-th bit on the wire (shifted out LSB first).
    function automatic logic [11:0] build_frame(input logic [3:0] m,
                                                input logic [3:0] p1,
                                                input logic [3:0] p2);
        if (RATE_HALF)
            build_frame = {4'b0000, p2[3], m[3], p1[2], m[2], p2[1], m[1], p1[0], m[0]};
        else
            build_frame = {p2[3], p1[3], m[3], p2[2], p1[2], m[2],
                           p2[1], p1[1], m[1], p2[0], p1[0], m[0]};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        msg_d    = msg_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        f_msg_d  = f_msg_q;
        f_p1_d   = f_p1_q;
        f_p2_d   = f_p2_q;
        ovr_d    = ovr_q;

        all_set  = f_msg_q & f_p1_q & f_p2_q;
        last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
        load     = all_set && ((state_q == S_IDLE) || last_bit);

        if (load) begin
            sr_d    = build_frame(msg_q, p1_q, p2_q);
            cnt_d   = 4'd0;
            state_d = S_SHIFT;
            f_msg_d = 1'b0;
            f_p1_d  = 1'b0;
            f_p2_d  = 1'b0;
        end else if (state_q == S_SHIFT) begin
            sr_d = {1'b0, sr_q[11:1]};
            if (last_bit) begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        // A strobe landing on the same edge that drains its flag is a normal capture.
        if (msg_vld) begin
            if (f_msg_q && !load) ovr_d = 1'b1;
            else begin
                msg_d   = msg;
                f_msg_d = 1'b1;
            end
        end
        if (c1_over) begin
            if (f_p1_q && !load) ovr_d = 1'b1;
            else begin
                p1_d   = c_1;
                f_p1_d = 1'b1;
            end
        end
        if (c2_over) begin
            if (f_p2_q && !load) ovr_d = 1'b1;
            else begin
                p2_d   = c_2;
                f_p2_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sr_q    <= 12'd0;
            msg_q   <= 4'd0;
            p1_q    <= 4'd0;
            p2_q    <= 4'd0;
            f_msg_q <= 1'b0;
            f_p1_q  <= 1'b0;
            f_p2_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            msg_q   <= msg_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            f_msg_q <= f_msg_d;
            f_p1_q  <= f_p1_d;
            f_p2_q  <= f_p2_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        busy     = (state_q == S_SHIFT);
        dout_vld = busy;
        dout     = busy & sr_q[0];
        sof      = busy && (cnt_q == 4'd0);
        eof      = busy && (cnt_q == CNT_LAST);
        ovr_err  = ovr_q;
    end

endmodule

// File: tb/tb_turbo_punc_mux.sv
// Directed bench for turbo_punc_mux: one rate-1/2 and one rate-1/3 instance
// share the same strobes; each scenario task checks the instance it targets.
module tb_turbo_punc_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] msg, c_1, c_2;
    logic       msg_vld, c1_over, c2_over;

    logic h_dout, h_vld, h_sof, h_eof, h_busy, h_ovr;
    logic t_dout, t_vld, t_sof, t_eof, t_busy, t_ovr;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected streams, bit i = i-th serial bit.
    logic [7:0]  exp_a_half  = 8'hE5;   // 1,0,1,0,0,1,1,1
    logic [11:0] exp_a_third = 12'hB99; // 1,0,0,1,1,0,0,1,1,1,0,1
    logic [7:0]  exp_b_half  = 8'h1A;   // msg=0100 c_1=1001 c_2=0011
    logic [7:0]  exp_ovr     = 8'hC7;   // msg=1011 c_1=0011 c_2=1100

    always #5 clk = ~clk;

    turbo_punc_mux #(.RATE_HALF(1'b1)) u_half (
        .clk(clk), .rst(rst),
        .msg(msg), .msg_vld(msg_vld), .c_1(c_1), .c1_over(c1_over), .c_2(c_2), .c2_over(c2_over),
        .dout(h_dout), .dout_vld(h_vld), .sof(h_sof), .eof(h_eof), .busy(h_busy), .ovr_err(h_ovr)
    );

    turbo_punc_mux #(.RATE_HALF(1'b0)) u_third (
        .clk(clk), .rst(rst),
        .msg(msg), .msg_vld(msg_vld), .c_1(c_1), .c1_over(c1_over), .c_2(c_2), .c2_over(c2_over),
        .dout(t_dout), .dout_vld(t_vld), .sof(t_sof), .eof(t_eof), .busy(t_busy), .ovr_err(t_ovr)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        msg_vld = 1'b0; c1_over = 1'b0; c2_over = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses the selected strobes for one rising edge; returns at the following falling edge.
    task automatic strobe(input logic sm, input logic s1, input logic s2,
                          input logic [3:0] vm, input logic [3:0] v1, input logic [3:0] v2);
        msg = vm; c_1 = v1; c_2 = v2;
        msg_vld = sm; c1_over = s1; c2_over = s2;
        @(negedge clk);
        msg_vld = 1'b0; c1_over = 1'b0; c2_over = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({h_dout, h_vld, h_sof, h_eof, h_busy, h_ovr} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_half: outputs=%b expected=000000", {h_dout, h_vld, h_sof, h_eof, h_busy, h_ovr});
        end
        tests_run++;
        if ({t_dout, t_vld, t_sof, t_eof, t_busy, t_ovr} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_third: outputs=%b expected=000000", {t_dout, t_vld, t_sof, t_eof, t_busy, t_ovr});
        end
    endtask

    task automatic test_rate_half();
        logic [7:0] got;
        do_reset();
        strobe(1, 1, 1, 4'b1011, 4'b0110, 4'b1100);
        tests_run++;
        if (h_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL half_latency: dout_vld=%b one cycle after strobes, expected 0", h_vld);
        end
        got = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got[i] = h_dout;
            tests_run++;
            if ({h_vld, h_busy, h_sof, h_eof} !== {1'b1, 1'b1, (i == 0), (i == 7)}) begin
                tests_failed++;
                $display("FAIL half_framing bit%0d: vld/busy/sof/eof=%b expected %b", i,
                         {h_vld, h_busy, h_sof, h_eof}, {1'b1, 1'b1, (i == 0), (i == 7)});
            end
        end
        tests_run++;
        if (got !== exp_a_half) begin
            tests_failed++;
            $display("FAIL half_bits: got=%b expected=%b (LSB first)", got, exp_a_half);
        end
        @(negedge clk);
        tests_run++;
        if ({h_vld, h_busy, h_dout, h_sof, h_eof, h_ovr} !== 6'b0) begin
            tests_failed++;
            $display("FAIL half_after: vld/busy/dout/sof/eof/ovr=%b expected 000000",
                     {h_vld, h_busy, h_dout, h_sof, h_eof, h_ovr});
        end
    endtask

    task automatic test_rate_third();
        logic [11:0] got;
        do_reset();
        strobe(1, 1, 1, 4'b1011, 4'b0110, 4'b1100);
        got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got[i] = t_dout;
            tests_run++;
            if ({t_vld, t_busy, t_sof, t_eof} !== {1'b1, 1'b1, (i == 0), (i == 11)}) begin
                tests_failed++;
                $display("FAIL third_framing bit%0d: vld/busy/sof/eof=%b expected %b", i,
                         {t_vld, t_busy, t_sof, t_eof}, {1'b1, 1'b1, (i == 0), (i == 11)});
            end
        end
        tests_run++;
        if (got !== exp_a_third) begin
            tests_failed++;
            $display("FAIL third_bits: got=%b expected=%b (LSB first)", got, exp_a_third);
        end
        @(negedge clk);
        tests_run++;
        if ({t_vld, t_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL third_after: vld/busy=%b expected 00", {t_vld, t_busy});
        end
    endtask

    task automatic test_staggered();
        logic [7:0] got;
        int early;
        do_reset();
        early = 0;
        strobe(1, 0, 0, 4'b1011, 4'b0000, 4'b0000);      // edge t
        for (int i = 0; i < 4; i++) begin
            if (h_vld !== 1'b0) early++;
            @(negedge clk);
        end
        strobe(0, 0, 1, 4'b0000, 4'b0000, 4'b1100);      // edge t+5
        for (int i = 0; i < 3; i++) begin
            if (h_vld !== 1'b0) early++;
            @(negedge clk);
        end
        strobe(0, 1, 0, 4'b0000, 4'b0110, 4'b0000);      // edge t+9
        if (h_vld !== 1'b0) early++;
        tests_run++;
        if (early != 0) begin
            tests_failed++;
            $display("FAIL stagger_early: %0d cycles with dout_vld=1 before last strobe + 2, expected 0", early);
        end
        @(negedge clk);
        tests_run++;
        if ({h_vld, h_sof} !== 2'b11) begin
            tests_failed++;
            $display("FAIL stagger_sof: vld/sof=%b two cycles after last strobe, expected 11", {h_vld, h_sof});
        end
        got = '0;
        got[0] = h_dout;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            got[i] = h_dout;
        end
        tests_run++;
        if (got !== exp_a_half) begin
            tests_failed++;
            $display("FAIL stagger_bits: got=%b expected=%b", got, exp_a_half);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_all;
        logic [15:0] got;
        do_reset();
        exp_all = {exp_b_half, exp_a_half};
        got = '0;
        strobe(1, 1, 1, 4'b1011, 4'b0110, 4'b1100);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            msg_vld = 1'b0; c1_over = 1'b0; c2_over = 1'b0;
            got[j] = h_dout;
            tests_run++;
            if ({h_vld, h_busy, h_sof, h_eof} !== {1'b1, 1'b1, (j % 8 == 0), (j % 8 == 7)}) begin
                tests_failed++;
                $display("FAIL b2b_framing cycle%0d: vld/busy/sof/eof=%b expected %b", j,
                         {h_vld, h_busy, h_sof, h_eof}, {1'b1, 1'b1, (j % 8 == 0), (j % 8 == 7)});
            end
            if (j == 2) begin msg = 4'b0100; msg_vld = 1'b1; end
            if (j == 3) begin c_1 = 4'b1001; c1_over = 1'b1; end
            if (j == 4) begin c_2 = 4'b0011; c2_over = 1'b1; end
        end
        tests_run++;
        if (got !== exp_all) begin
            tests_failed++;
            $display("FAIL b2b_bits: got=%h expected=%h", got, exp_all);
        end
        tests_run++;
        if (h_ovr !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ovr: ovr_err=%b expected 0", h_ovr);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] got;
        do_reset();
        strobe(0, 1, 0, 4'b0000, 4'h3, 4'b0000);
        tests_run++;
        if (h_ovr !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_first: ovr_err=%b after single strobe, expected 0", h_ovr);
        end
        @(negedge clk);
        strobe(0, 1, 0, 4'b0000, 4'h5, 4'b0000);
        tests_run++;
        if (h_ovr !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_set: ovr_err=%b after second c1_over, expected 1", h_ovr);
        end
        strobe(1, 0, 1, 4'b1011, 4'h0, 4'b1100);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got[i] = h_dout;
        end
        tests_run++;
        if (got !== exp_ovr) begin
            tests_failed++;
            $display("FAIL ovr_bits: got=%b expected=%b (p1 from first word)", got, exp_ovr);
        end
        @(negedge clk);
        tests_run++;
        if (h_ovr !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_sticky: ovr_err=%b after frame, expected 1", h_ovr);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        int stray;
        do_reset();
        strobe(1, 0, 0, 4'b1011, 4'h0, 4'h0);
        strobe(1, 0, 0, 4'b0000, 4'h0, 4'h0);      // overrun, sets ovr_err
        strobe(0, 1, 1, 4'b0000, 4'b0110, 4'b1100);
        for (int i = 0; i < 5; i++) @(negedge clk);  // showing bit 4
        tests_run++;
        if ({h_vld, h_ovr} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midrst_pre: vld/ovr=%b at bit 4, expected 11", {h_vld, h_ovr});
        end
        // Partially load the flags too, so a leftover flag would start a bogus frame.
        msg = 4'hF; msg_vld = 1'b1; c1_over = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        msg_vld = 1'b0; c1_over = 1'b0;
        tests_run++;
        if ({h_vld, h_busy, h_sof, h_eof, h_ovr, h_dout} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midrst_out: vld/busy/sof/eof/ovr/dout=%b expected 000000",
                     {h_vld, h_busy, h_sof, h_eof, h_ovr, h_dout});
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (h_vld !== 1'b0 || h_eof !== 1'b0) stray++;
        end
        strobe(0, 0, 1, 4'h0, 4'h0, 4'b1100);         // only c_2: must not complete a frame
        @(negedge clk);
        if (h_vld !== 1'b0) stray++;
        @(negedge clk);
        if (h_vld !== 1'b0) stray++;
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL midrst_flags: %0d cycles of output after reset, expected 0", stray);
        end
        strobe(1, 1, 0, 4'b1011, 4'b0110, 4'h0);
        got = '0;
        @(negedge clk);
        tests_run++;
        if (h_sof !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_sof: sof=%b for fresh frame, expected 1", h_sof);
        end
        got[0] = h_dout;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            got[i] = h_dout;
        end
        tests_run++;
        if (got !== exp_a_half || h_eof !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_fresh: got=%b eof=%b expected=%b eof=1", got, h_eof, exp_a_half);
        end
    endtask

    initial begin
        rst = 1'b1;
        msg = '0; c_1 = '0; c_2 = '0;
        msg_vld = 1'b0; c1_over = 1'b0; c2_over = 1'b0;
        test_reset();
        test_rate_half();
        test_rate_third();
        test_staggered();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
